fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage, directly downstream of the branch/next-PC logic.
- Owns the architectural PC register and drives the instruction-memory address.
- Applies the redirect decision (pc_sel / pc_branch / PC+4) each cycle, handles stall, flush and halt.
- Produces the IF/ID pipeline register (PC, instruction, valid) consumed by decode, plus a fetched-instruction counter.

Parameters:
- PC_WIDTH, 9, width of PC register and instruction-memory byte address.
- RESET_PC, 0, PC value loaded on reset (PC_WIDTH bits, word aligned).
- NOP_INSTR, 32'h00000013, instruction placed in IF/ID on flush, boot or halt (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit hold request; freezes PC and IF/ID
- pc_sel  in  1  1 = take pc_branch, 0 = sequential PC+4
- pc_branch  in  32  redirect target from branch logic
- halt  in  1  halt request; stage enters HALTED
- instr_mem_rdata  in  32  instruction at instr_mem_addr, combinational read, same cycle
- instr_mem_addr  out  PC_WIDTH  current PC (combinational from PC register)
- if_id_pc  out  PC_WIDTH  PC of instruction held in IF/ID
- if_id_instr  out  32  instruction held in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
- pc_fault  out  1  sticky: illegal redirect target seen
- fetch_state  out  2  00 BOOT, 01 RUN, 10 HALTED
- fetch_count  out  32  number of instructions loaded into IF/ID with valid=1

Behaviour:
Reset (asynchronous, any time including mid-operation):
- PC = RESET_PC; if_id_pc = 0; if_id_instr = NOP_INSTR; if_id_valid = 0.
- pc_fault = 0; fetch_state = BOOT; fetch_count = 0.

BOOT:
- Exactly one cycle after reset deassertion; all inputs ignored.
- PC holds RESET_PC; IF/ID stays NOP/invalid.
- Next state: RUN.

RUN, per cycle, priority halt > fault > pc_sel > stall > advance:
- halt=1: state goes to HALTED; PC holds; IF/ID loads NOP, valid 0.
- pc_sel=1 with pc_branch[1:0] != 0 or pc_branch[31:PC_WIDTH] != 0: fault. pc_fault is set; state goes to HALTED; PC holds; IF/ID loads NOP, valid 0.
- pc_sel=1, legal target: PC loads pc_branch[PC_WIDTH-1:0]; IF/ID flushed (NOP, valid 0). A simultaneous stall is ignored because the redirect overrides it.
- stall=1, pc_sel=0: PC, IF/ID and fetch_count all hold.
- Otherwise (advance): IF/ID loads {PC, instr_mem_rdata} with valid 1; PC loads PC+4 modulo 2^PC_WIDTH (the top address wraps to 0 with no fault); fetch_count increments.

HALTED:
- PC, if_id_*, fetch_count and pc_fault all frozen; all inputs ignored.
- Exits only via reset.

Other rules:
- fetch_count wraps 2^32-1 to 0.
- instr_mem_addr always equals the PC register; no added latency.
- Latency: an instruction fetched in cycle N appears in IF/ID in cycle N+1. A redirect in cycle N makes instr_mem_addr equal the target in cycle N+1.
- fetch_state encoding 11 is unreachable; if entered, the next state is HALTED.

Test Plan:
1. Reset, then 4 cycles with no stall and memory returning 0xA0+addr -> BOOT for 1 cycle. instr_mem_addr runs 0, 4, 8, 12. if_id_pc/valid shows 0/1 then 4/1; fetch_count = 3 after cycle 4.
2. With PC=8, assert pc_sel=1, pc_branch=0x40, stall=1 in the same cycle -> next cycle PC=0x40 and if_id_valid=0, instr=0x00000013. The following cycle if_id_pc=0x40, valid=1.
3. stall=1 for 3 cycles at PC=0x10 -> PC, IF/ID and fetch_count unchanged for all 3 cycles. Release -> PC=0x14.
4. PC=0x1FC with PC_WIDTH=9 and advance -> PC wraps to 0x000, pc_fault stays 0.
5. pc_sel=1, pc_branch=0x42 -> pc_fault=1, fetch_state=10, PC unchanged. Later pc_sel, stall and halt have no effect; reset clears to BOOT.
6. halt=1 together with pc_sel=1 -> HALTED, PC not redirected, if_id_valid=0. Async reset pulsed mid-cycle -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: branch-logic inputs, instruction-memory port and IF/ID outputs of the fetch stage
interface fetch_stage_if #(
    parameter int PC_WIDTH = 9
);
    logic                stall;
    logic                pc_sel;
    logic [31:0]         pc_branch;
    logic                halt;
    logic [31:0]         instr_mem_rdata;
    logic [PC_WIDTH-1:0] instr_mem_addr;
    logic [PC_WIDTH-1:0] if_id_pc;
    logic [31:0]         if_id_instr;
    logic                if_id_valid;
    logic                pc_fault;
    logic [1:0]          fetch_state;
    logic [31:0]         fetch_count;

    modport master (
        output stall, pc_sel, pc_branch, halt, instr_mem_rdata,
        input  instr_mem_addr, if_id_pc, if_id_instr, if_id_valid, pc_fault, fetch_state, fetch_count
    );

    modport slave (
        input  stall, pc_sel, pc_branch, halt, instr_mem_rdata,
        output instr_mem_addr, if_id_pc, if_id_instr, if_id_valid, pc_fault, fetch_state, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, redirect/stall/halt handling and IF/ID pipeline register
module fetch_stage #(
    parameter int                  PC_WIDTH  = 9,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]         NOP_INSTR = 32'h00000013
) (
    input logic          clk,
    input logic          reset,
    fetch_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_BOOT   = 2'b00,
        S_RUN    = 2'b01,
        S_HALTED = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_if_pc;
    logic [31:0]         r_if_instr;
    logic                r_if_valid;
    logic                r_fault;
    logic [31:0]         r_count;
    logic                w_bad_target;

    // A redirect target must be word aligned and fit inside the PC width
    assign w_bad_target = (|bus.pc_branch[1:0]) || (|bus.pc_branch[31:PC_WIDTH]);

    assign bus.instr_mem_addr = r_pc;
    assign bus.if_id_pc       = r_if_pc;
    assign bus.if_id_instr    = r_if_instr;
    assign bus.if_id_valid    = r_if_valid;
    assign bus.pc_fault       = r_fault;
    assign bus.fetch_state    = r_state;
    assign bus.fetch_count    = r_count;

    // Fetch FSM: halt > fault > redirect > stall > advance while running; HALTED is frozen until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN: begin
                    if (bus.halt) begin
                        r_state    <= S_HALTED;
                        r_if_instr <= NOP_INSTR;
                        r_if_valid <= 1'b0;
                    end else if (bus.pc_sel && w_bad_target) begin
                        r_state    <= S_HALTED;
                        r_fault    <= 1'b1;
                        r_if_instr <= NOP_INSTR;
                        r_if_valid <= 1'b0;
                    end else if (bus.pc_sel) begin
                        r_pc       <= bus.pc_branch[PC_WIDTH-1:0];
                        r_if_instr <= NOP_INSTR;
                        r_if_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        r_pc       <= r_pc + PC_WIDTH'(4);
                        r_if_pc    <= r_pc;
                        r_if_instr <= bus.instr_mem_rdata;
                        r_if_valid <= 1'b1;
                        r_count    <= r_count + 32'd1;
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus hand sequences for fault, halt and async reset
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    fetch_stage_if #(.PC_WIDTH(9)) bus ();

    fetch_stage #(.PC_WIDTH(9)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Instruction memory model: each word reads back as 0xA0 + its byte address
    always_comb bus.instr_mem_rdata = 32'hA0 + 32'(bus.instr_mem_addr);

    typedef struct {
        logic        st;
        logic        sel;
        logic [31:0] br;
        logic        h;
        logic [8:0]  pc;
        logic [8:0]  ipc;
        logic [31:0] ins;
        logic        v;
        logic [1:0]  s;
        logic [31:0] cnt;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] pc, input logic [8:0] ipc,
                           input logic [31:0] ins, input logic v, input logic [1:0] s,
                           input logic [31:0] cnt, input logic f);
        chk({tag, ".pc"}, 32'(bus.instr_mem_addr), 32'(pc));
        chk({tag, ".if_pc"}, 32'(bus.if_id_pc), 32'(ipc));
        chk({tag, ".if_instr"}, bus.if_id_instr, ins);
        chk({tag, ".if_valid"}, 32'(bus.if_id_valid), 32'(v));
        chk({tag, ".state"}, 32'(bus.fetch_state), 32'(s));
        chk({tag, ".count"}, bus.fetch_count, cnt);
        chk({tag, ".fault"}, 32'(bus.pc_fault), 32'(f));
    endtask

    task automatic step(input logic st, input logic sel, input logic [31:0] br, input logic h);
        bus.stall = st;
        bus.pc_sel = sel;
        bus.pc_branch = br;
        bus.halt = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        bus.stall = 0;
        bus.pc_sel = 0;
        bus.pc_branch = 0;
        bus.halt = 0;
        //            st sel br         h  pc      ipc     ins           v  s      cnt
        tv[0]  = '{0, 0, 32'h0,   0, 9'h000, 9'h000, 32'h00000013, 0, 2'b01, 32'd0};
        tv[1]  = '{0, 0, 32'h0,   0, 9'h004, 9'h000, 32'h000000A0, 1, 2'b01, 32'd1};
        tv[2]  = '{0, 0, 32'h0,   0, 9'h008, 9'h004, 32'h000000A4, 1, 2'b01, 32'd2};
        tv[3]  = '{1, 1, 32'h40,  0, 9'h040, 9'h004, 32'h00000013, 0, 2'b01, 32'd2};
        tv[4]  = '{0, 0, 32'h0,   0, 9'h044, 9'h040, 32'h000000E0, 1, 2'b01, 32'd3};
        tv[5]  = '{0, 1, 32'h0C,  0, 9'h00C, 9'h040, 32'h00000013, 0, 2'b01, 32'd3};
        tv[6]  = '{0, 0, 32'h0,   0, 9'h010, 9'h00C, 32'h000000AC, 1, 2'b01, 32'd4};
        tv[7]  = '{1, 0, 32'h0,   0, 9'h010, 9'h00C, 32'h000000AC, 1, 2'b01, 32'd4};
        tv[8]  = '{1, 0, 32'h0,   0, 9'h010, 9'h00C, 32'h000000AC, 1, 2'b01, 32'd4};
        tv[9]  = '{1, 0, 32'h0,   0, 9'h010, 9'h00C, 32'h000000AC, 1, 2'b01, 32'd4};
        tv[10] = '{0, 0, 32'h0,   0, 9'h014, 9'h010, 32'h000000B0, 1, 2'b01, 32'd5};
        tv[11] = '{0, 1, 32'h1FC, 0, 9'h1FC, 9'h010, 32'h00000013, 0, 2'b01, 32'd5};
        tv[12] = '{0, 0, 32'h0,   0, 9'h000, 9'h1FC, 32'h0000029C, 1, 2'b01, 32'd6};
        tv[13] = '{0, 0, 32'h0,   0, 9'h004, 9'h000, 32'h000000A0, 1, 2'b01, 32'd7};

        do_reset();
        chk_all("reset", 9'h000, 9'h000, 32'h13, 0, 2'b00, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(tv[i].st, tv[i].sel, tv[i].br, tv[i].h);
            chk_all($sformatf("vec%0d", i), tv[i].pc, tv[i].ipc, tv[i].ins, tv[i].v, tv[i].s, tv[i].cnt, 0);
        end

        // Misaligned redirect faults and freezes the stage
        step(0, 1, 32'h42, 0);
        chk_all("fault", 9'h004, 9'h000, 32'h13, 0, 2'b10, 7, 1);
        step(0, 1, 32'h40, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk_all("frozen", 9'h004, 9'h000, 32'h13, 0, 2'b10, 7, 1);
        do_reset();
        chk_all("reset2", 9'h000, 9'h000, 32'h13, 0, 2'b00, 0, 0);

        // Out-of-range target (bit above PC width) also faults
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h200, 0);
        chk_all("range_fault", 9'h004, 9'h000, 32'h13, 0, 2'b10, 1, 1);

        // Inputs during BOOT are ignored
        do_reset();
        step(0, 1, 32'h42, 1);
        chk_all("boot_ignore", 9'h000, 9'h000, 32'h13, 0, 2'b01, 0, 0);

        // Halt beats a simultaneous redirect
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h40, 1);
        chk_all("halt", 9'h008, 9'h004, 32'h13, 0, 2'b10, 2, 0);

        // Asynchronous reset takes effect between clock edges
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 9'h000, 9'h000, 32'h13, 0, 2'b00, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 0);
        chk_all("after_async", 9'h000, 9'h000, 32'h13, 0, 2'b01, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
